loadable_memory: RTL and testbench
==================================

LOADABLE_MEMORY -- requirements
Module: loadable_memory

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, sets the address width; depth is 2^ADDR_WIDTH bytes.
REQ-002 Parameter DATA_WIDTH, default 8, sets the byte width of storage, read data and load data.
REQ-003 One clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 addr  input  ADDR_WIDTH  processor read address.
REQ-007 strobe  input  1  processor read request, sampled at the clk rising edge.
REQ-008 dataRead  output  DATA_WIDTH  registered read data.
REQ-009 loadStart  input  1  single-cycle pulse that begins a program load at address 0.
REQ-010 loadValid  input  1  loadData holds a valid byte this cycle.
REQ-011 loadData  input  DATA_WIDTH  program byte to write.
REQ-012 loadLast  input  1  qualified by loadValid; marks the final byte of the load.
REQ-013 cpuHold  output  1  high while a load is in progress; the processor stalls on it.
REQ-014 loadCount  output  ADDR_WIDTH+1  number of bytes written by the current or most recent load.
REQ-015 overflow  output  1  sticky flag; the load wrote past the top address.

Function
REQ-016 FSM states: IDLE, LOADING, DONE; reset state is IDLE.
REQ-017 IDLE or DONE, loadStart=1 -> LOADING next cycle; write pointer := 0, loadCount := 0, overflow := 0.
REQ-018 LOADING, loadValid=1: memory[pointer] := loadData; pointer := pointer+1, modulo 2^ADDR_WIDTH; loadCount := loadCount+1, saturating at 2^ADDR_WIDTH.
REQ-019 LOADING, loadValid=1, pointer = all-ones: the write happens, pointer wraps to 0, overflow := 1 only if loadLast=0 (the load continues past the top address).
REQ-020 LOADING, loadValid=1 and loadLast=1: the byte is written, then -> DONE.
REQ-021 LOADING, loadStart=1: the load restarts at address 0 with counters cleared (REQ-017); a loadValid in the same cycle is ignored.
REQ-022 loadValid outside LOADING: ignored; memory and counters unchanged.
REQ-023 cpuHold = 1 exactly when state = LOADING (combinational decode of the state register).
REQ-024 Read protocol: strobe=1 at edge N -> dataRead = memory[addr] after edge N; zero wait states; 1-cycle latency.
REQ-025 strobe=0: dataRead holds its previous value.
REQ-026 Reads are served in every state, including LOADING.
REQ-027 Read and load write to the same address in the same cycle: dataRead returns the old contents; the new byte is visible from the next read.
REQ-028 Memory contents are uninitialised until loaded and are not cleared by reset.

Reset
REQ-029 reset=1 forces, asynchronously: state := IDLE, pointer := 0, loadCount := 0, overflow := 0, dataRead := 0, cpuHold := 0.
REQ-030 reset asserted mid-load: the load is aborted; bytes already written remain in memory; no partial write occurs in the reset cycle.
REQ-031 After reset deasserts, the block accepts strobe and loadStart on the first rising edge.

Verification
REQ-032 Load 0C 0A 1C 14 02 01 FF 8D 00 02, with loadLast on the byte 02 at the end -> cpuHold high for the load; DONE; loadCount=10; reads of addr 0..9 return the same bytes with 1-cycle latency.
REQ-033 Back-to-back strobe on addr 2, 3, 4 -> dataRead 1C, 14, 02 on successive cycles; strobe low one cycle -> dataRead stays 02.
REQ-034 256 bytes 00..FF with loadLast on FF -> overflow=0, loadCount=256. Then 257 bytes with loadLast on the 257th (value AA) -> overflow=1, loadCount=256 (saturated), memory[0]=AA.
REQ-035 During a load, strobe on addr 5 in the same cycle as the write of 77 to addr 5 (old value 01) -> dataRead=01; the next read of addr 5 -> 77.
REQ-036 Assert reset after 4 of 10 load bytes -> state IDLE, cpuHold=0, loadCount=0, dataRead=0; addr 0..3 keep the loaded bytes.
REQ-037 loadStart while loading (after 3 bytes), then bytes 11 22 with loadLast on 22 -> addr 0=11, addr 1=22, loadCount=2.

Source files
------------

// File: rtl/loadable_memory.sv
// ============================================================================
// loadable_memory : byte RAM with a streaming program loader and a registered read port
// Rev 1.0
// ============================================================================
`default_nettype none

module loadable_memory #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  strobe,
  output logic [DATA_WIDTH-1:0] dataRead,
  input  logic                  loadStart,
  input  logic                  loadValid,
  input  logic [DATA_WIDTH-1:0] loadData,
  input  logic                  loadLast,
  output logic                  cpuHold,
  output logic [ADDR_WIDTH:0]   loadCount,
  output logic                  overflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_LOADING = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  localparam logic [ADDR_WIDTH-1:0] PTR_TOP = '1;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   CNT_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q,   ptr_d;
  logic [ADDR_WIDTH:0]   cnt_q,   cnt_d;
  logic                  ovf_q,   ovf_d;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  write_en;

  // A restart pulse takes priority over any byte presented in the same cycle.
  assign write_en = (state_q == ST_LOADING) && loadValid && !loadStart;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (state_q != ST_IDLE && state_q != ST_LOADING && state_q != ST_DONE) begin
      state_d = ST_IDLE;
    end
    if (loadStart) begin
      state_d = ST_LOADING;
      ptr_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else if (write_en) begin
      ptr_d = ptr_q + PTR_ONE;
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_ONE;
      end
      if (ptr_q == PTR_TOP && !loadLast) begin
        ovf_d = 1'b1;
      end
      if (loadLast) begin
        state_d = ST_DONE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage is never cleared; reset only blocks a write in the cycle it is asserted.
  always_ff @(posedge clk) begin
    if (write_en && !reset) begin
      mem_q[ptr_q] <= loadData;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (strobe) begin
      rdata_q <= mem_q[addr];
    end
  end

  assign dataRead  = rdata_q;
  assign cpuHold   = (state_q == ST_LOADING);
  assign loadCount = cnt_q;
  assign overflow  = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_loadable_memory.sv
// ============================================================================
// tb_loadable_memory : directed scenarios plus random traffic against a behavioural model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_loadable_memory;

  logic       clk;
  logic       reset;
  logic [7:0] addr;
  logic       strobe;
  logic [7:0] dataRead;
  logic       loadStart;
  logic       loadValid;
  logic [7:0] loadData;
  logic       loadLast;
  logic       cpuHold;
  logic [8:0] loadCount;
  logic       overflow;

  loadable_memory #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .addr      (addr),
    .strobe    (strobe),
    .dataRead  (dataRead),
    .loadStart (loadStart),
    .loadValid (loadValid),
    .loadData  (loadData),
    .loadLast  (loadLast),
    .cpuHold   (cpuHold),
    .loadCount (loadCount),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: "loading" flag, write pointer, byte count, overflow, memory image.
  bit m_loading;
  int m_ptr;
  int m_cnt;
  bit m_ovf;
  int m_mem [256];
  bit m_known [256];
  int m_rd;
  bit m_rdk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    int a;
    a = int'(addr);
    if (!reset) begin
      if (strobe) begin
        m_rdk = m_known[a];
        if (m_known[a]) m_rd = m_mem[a];
      end
      if (loadStart) begin
        m_loading = 1'b1;
        m_ptr = 0;
        m_cnt = 0;
        m_ovf = 1'b0;
      end else if (m_loading && loadValid) begin
        m_mem[m_ptr] = int'(loadData);
        m_known[m_ptr] = 1'b1;
        if (m_ptr == 255 && !loadLast) m_ovf = 1'b1;
        m_ptr = (m_ptr + 1) % 256;
        m_cnt = (m_cnt < 256) ? m_cnt + 1 : 256;
        if (loadLast) m_loading = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    check_val("cpuHold", {31'd0, cpuHold}, {31'd0, m_loading});
    check_val("loadCount", {23'd0, loadCount}, m_cnt);
    check_val("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    if (m_rdk) check_val("dataRead", {24'd0, dataRead}, m_rd);
  endtask

  // Asserted between edges so the asynchronous clear is observed without a clock.
  task automatic do_reset();
    reset = 1'b1;
    #2;
    m_loading = 1'b0;
    m_ptr = 0;
    m_cnt = 0;
    m_ovf = 1'b0;
    m_rd = 0;
    m_rdk = 1'b1;
    check_val("rst_cpuHold", {31'd0, cpuHold}, 0);
    check_val("rst_loadCount", {23'd0, loadCount}, 0);
    check_val("rst_overflow", {31'd0, overflow}, 0);
    check_val("rst_dataRead", {24'd0, dataRead}, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic start_load();
    loadStart = 1'b1;
    tick();
    loadStart = 1'b0;
  endtask

  task automatic load_byte(input logic [7:0] d, input logic last);
    loadValid = 1'b1;
    loadData  = d;
    loadLast  = last;
    tick();
    loadValid = 1'b0;
    loadLast  = 1'b0;
  endtask

  task automatic read(input logic [7:0] a);
    strobe = 1'b1;
    addr   = a;
    tick();
    strobe = 1'b0;
  endtask

  logic [7:0] prog [10];
  logic [7:0] tmp;

  initial begin
    prog[0] = 8'h0C; prog[1] = 8'h0A; prog[2] = 8'h1C; prog[3] = 8'h14; prog[4] = 8'h02;
    prog[5] = 8'h01; prog[6] = 8'hFF; prog[7] = 8'h8D; prog[8] = 8'h00; prog[9] = 8'h02;
    for (int i = 0; i < 256; i++) begin
      m_mem[i] = 0;
      m_known[i] = 1'b0;
    end
    m_rdk = 1'b0;
    reset = 1'b1; addr = '0; strobe = 1'b0; loadStart = 1'b0;
    loadValid = 1'b0; loadData = '0; loadLast = 1'b0;
    do_reset();

    // Ten-byte program load, then read back with one-cycle latency.
    start_load();
    check_val("hold_during_load", {31'd0, cpuHold}, 1);
    for (int i = 0; i < 10; i++) load_byte(prog[i], i == 9);
    check_val("ld10_hold", {31'd0, cpuHold}, 0);
    check_val("ld10_cnt", {23'd0, loadCount}, 10);
    for (int i = 0; i < 10; i++) begin
      read(8'(i));
      check_val("ld10_rd", {24'd0, dataRead}, {24'd0, prog[i]});
    end

    // Back-to-back strobes, then a idle cycle holds the last value.
    read(8'd2); check_val("b2b_2", {24'd0, dataRead}, 32'h1C);
    read(8'd3); check_val("b2b_3", {24'd0, dataRead}, 32'h14);
    read(8'd4); check_val("b2b_4", {24'd0, dataRead}, 32'h02);
    tick();     check_val("b2b_hold", {24'd0, dataRead}, 32'h02);

    // Read of addr 5 in the same cycle it is overwritten returns the old byte.
    start_load();
    for (int i = 0; i < 5; i++) load_byte(prog[i], 1'b0);
    strobe = 1'b1; addr = 8'd5;
    load_byte(8'h77, 1'b0);
    strobe = 1'b0;
    check_val("rw_old", {24'd0, dataRead}, 32'h01);
    read(8'd5);
    check_val("rw_new", {24'd0, dataRead}, 32'h77);
    load_byte(8'h00, 1'b1);

    // Reset after four of ten bytes, with a fifth byte presented during reset.
    start_load();
    for (int i = 0; i < 4; i++) load_byte(8'hA0 + 8'(i), 1'b0);
    loadValid = 1'b1; loadData = 8'hEE;
    do_reset();
    loadValid = 1'b0;
    check_val("abort_hold", {31'd0, cpuHold}, 0);
    check_val("abort_cnt", {23'd0, loadCount}, 0);
    check_val("abort_rd", {24'd0, dataRead}, 0);
    for (int i = 0; i < 4; i++) begin
      read(8'(i));
      check_val("abort_keep", {24'd0, dataRead}, 32'hA0 + i);
    end
    read(8'd4);
    check_val("abort_nowrite", {24'd0, dataRead}, {24'd0, prog[4]});

    // Restart mid-load; the byte alongside the restart pulse is dropped.
    start_load();
    load_byte(8'h33, 1'b0); load_byte(8'h44, 1'b0); load_byte(8'h55, 1'b0);
    loadStart = 1'b1;
    load_byte(8'h99, 1'b0);
    loadStart = 1'b0;
    load_byte(8'h11, 1'b0);
    load_byte(8'h22, 1'b1);
    check_val("restart_cnt", {23'd0, loadCount}, 2);
    read(8'd0); check_val("restart_a0", {24'd0, dataRead}, 32'h11);
    read(8'd1); check_val("restart_a1", {24'd0, dataRead}, 32'h22);

    // Exactly full load, then one byte past the top.
    start_load();
    for (int i = 0; i < 256; i++) load_byte(8'(i), i == 255);
    check_val("full_ovf", {31'd0, overflow}, 0);
    check_val("full_cnt", {23'd0, loadCount}, 256);
    start_load();
    for (int i = 0; i < 256; i++) load_byte(8'(i) ^ 8'h5A, 1'b0);
    load_byte(8'hAA, 1'b1);
    check_val("wrap_ovf", {31'd0, overflow}, 1);
    check_val("wrap_cnt", {23'd0, loadCount}, 256);
    read(8'd0); check_val("wrap_a0", {24'd0, dataRead}, 32'hAA);
    read(8'd1); check_val("wrap_a1", {24'd0, dataRead}, 32'h5B);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 399) == 0) begin
        loadValid = 1'($urandom);
        loadData  = 8'($urandom);
        do_reset();
      end
      tmp = 8'($urandom);
      addr      = tmp;
      strobe    = 1'($urandom);
      loadStart = ($urandom_range(0, 39) == 0);
      loadValid = 1'($urandom);
      loadData  = 8'($urandom);
      loadLast  = ($urandom_range(0, 29) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
